// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and DesignWare status to fflags mapping
package fp_pkg;

  // RISC-V accrued-exception layout: nv is bit 4, nx is bit 0.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INV     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  // Only the invalid, tiny, huge and inexact bits carry exception meaning.
  // Underflow is reported only when the tiny result was also inexact.
  // A multiply never divides by zero, so dz stays 0.
  function automatic fflags_t dw_status_to_fflags(input logic [7:0] status);
    fflags_t f;
    f.nv = status[ST_INV];
    f.dz = 1'b0;
    f.of = status[ST_HUGE];
    f.uf = status[ST_TINY] & status[ST_INEXACT];
    f.nx = status[ST_INEXACT];
    return f;
  endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// rtl/fp_res_fifo.sv - generic synchronous FIFO with registered full/empty
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, wdata_i   write strobe and data (ignored when full)
//   pop_i             read strobe (ignored when empty)
//   rdata_o           head entry, reads 0 while empty
//   full_o, empty_o   occupancy status from registered count
module fp_res_fifo
  import fp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

  // No pass-through: a push while full is dropped even if a pop frees a slot.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fp_mul_result_stage.sv
// rtl/fp_mul_result_stage.sv - registered result stage after the fp multiplier
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               upstream handshake (in_ready = !full)
//   in_o, in_status, in_tag         multiplier product, DW status, caller tag
//   out_valid/out_ready             downstream handshake on the FIFO head
//   out_data, out_fflags, out_tag   head result, mapped flags, tag
//   acc_fflags, acc_clr             sticky flags of popped results, clear
module fp_mul_result_stage
  import fp_pkg::*;
#(
  parameter int N_DATA = 64,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_DATA-1:0] in_o,
  input  logic [7:0]        in_status,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_DATA-1:0] out_data,
  output logic [4:0]        out_fflags,
  output logic [TAG_W-1:0]  out_tag,
  output logic [4:0]        acc_fflags,
  input  logic              acc_clr
);

  localparam int ENTRY_W = N_DATA + 5 + TAG_W;

  logic               full, empty, push, pop;
  fflags_t            in_flags;
  logic [ENTRY_W-1:0] wdata, rdata;
  logic [4:0]         acc_q, acc_d;

  // Flags are mapped before storage so the head presents them directly.
  assign in_flags = dw_status_to_fflags(in_status);
  assign wdata    = {in_o, in_flags, in_tag};

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fp_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {out_data, out_fflags, out_tag} = rdata;

  // Clear takes effect before accrual, so clear+pop leaves only the head flags.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) acc_d = '0;
    if (pop)     acc_d = acc_d | out_fflags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_fflags = acc_q;

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// tb/tb_fp_mul_result_stage.sv - scoreboard bench for fp_mul_result_stage
module tb_fp_mul_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_o;
  logic [7:0]  in_status;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_fflags;
  logic [3:0]  out_tag;
  logic [4:0]  acc_fflags;
  logic        acc_clr;

  fp_mul_result_stage #(.N_DATA(64), .TAG_W(4), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_o       (in_o),
    .in_status  (in_status),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_fflags (out_fflags),
    .out_tag    (out_tag),
    .acc_fflags (acc_fflags),
    .acc_clr    (acc_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  fl;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [4:0]  acc_model = '0;
  logic        mon_en = 1'b0;
  logic        rand_en = 1'b0;
  logic        held_v = 1'b0;
  exp_t        held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference flag rules: invalid -> NV, huge -> OF, inexact -> NX,
  // tiny and inexact -> UF, DZ never.
  function automatic logic [4:0] ref_flags(input logic [7:0] st);
    bit invalid, tiny, huge, inexact;
    invalid = st[2];
    tiny    = st[3];
    huge    = st[4];
    inexact = st[5];
    return {invalid, 1'b0, huge, tiny && inexact, inexact};
  endfunction

  task automatic send(input logic [63:0] d, input logic [7:0] st,
                      input logic [3:0] tg, input logic [4:0] ef);
    bit done;
    exp_t e;
    in_valid = 1'b1; in_o = d; in_status = st; in_tag = tg;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = d; e.fl = ef; e.tag = tg;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compares the head on every pop, checks hold-stability under
  // backpressure and tracks the accrued flags model.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      exp_t e;
      logic [4:0] pf;
      bit   p;
      pf = '0;
      p  = out_valid && out_ready;
      chk("acc_fflags", 64'(acc_fflags), 64'(acc_model));
      if (held_v && out_valid) begin
        chk("hold_data", out_data, held.data);
        chk("hold_tag", 64'(out_tag), 64'(held.tag));
      end
      if (p) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pop", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_fflags", 64'(out_fflags), 64'(e.fl));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          pf = e.fl;
        end
      end
      held_v = out_valid && !out_ready;
      held.data = out_data; held.fl = out_fflags; held.tag = out_tag;
      if (acc_clr) acc_model = p ? pf : 5'd0;
      else if (p)  acc_model = acc_model | pf;
    end
  end

  initial begin
    while (1) begin
      @(posedge clk); #1;
      if (rand_en) begin
        out_ready = ($urandom_range(0, 3) != 0);
        acc_clr   = ($urandom_range(0, 7) == 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_o = '0; in_status = '0; in_tag = '0;
    out_ready = 1'b0; acc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_acc", 64'(acc_fflags), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_fflags", 64'(out_fflags), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    mon_en = 1'b1;

    // 2.0 x 3.0, visible the cycle after the push
    out_ready = 1'b1;
    send(64'h4018000000000000, 8'h00, 4'd3, 5'b00000);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_data", out_data, 64'h4018000000000000);
    chk("lat_out_tag", 64'(out_tag), 64'd3);

    // flag mapping, directed expectations
    send(64'h7ff8000000000000, 8'h04, 4'd4, 5'b10000);
    send(64'h7ff0000000000000, 8'h30, 4'd5, 5'b00101);
    send(64'h0000000000000001, 8'h28, 4'd6, 5'b00011);
    send(64'h0010000000000000, 8'h08, 4'd7, 5'b00000);
    drain();

    // backpressure: A,B fill, C held upstream
    out_ready = 1'b0;
    send(64'hA, 8'h00, 4'd10, 5'b0);
    send(64'hB, 8'h20, 4'd11, 5'b00001);
    chk("bp_full", 64'(in_ready), 64'd0);
    fork
      send(64'hC, 8'h10, 4'd12, 5'b00100);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_head_A", out_data, 64'hA);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);

    // streaming: 16 back-to-back with no bubbles
    for (int i = 0; i < 16; i++) begin
      send(64'h1000 + 64'(i), 8'h00, 4'(i), 5'b0);
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drain();

    // accrual and clear+pop
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(64'h1, 8'h30, 4'd1, 5'b00101);
    send(64'h2, 8'h04, 4'd2, 5'b10000);
    drain();
    @(posedge clk); #1;
    chk("acc_or", 64'(acc_fflags), 64'b10101);
    out_ready = 1'b0;
    send(64'h3, 8'h20, 4'd3, 5'b00001);
    acc_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk("acc_clr_pop", 64'(acc_fflags), 64'b00001);
    chk("acc_clr_pop_empty", 64'(out_valid), 64'd0);

    // asynchronous reset with two entries held
    out_ready = 1'b0;
    send(64'h11, 8'h04, 4'd1, 5'b10000);
    send(64'h22, 8'h04, 4'd2, 5'b10000);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_acc", 64'(acc_fflags), 64'd0);
    sb_q.delete();
    acc_model = '0;
    held_v = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(64'h33, 8'h00, 4'd9, 5'b0);
    chk("post_rst_single", out_data, 64'h33);
    drain();

    // randomized traffic against the reference flag rules
    rand_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [63:0] d;
      logic [7:0]  st;
      logic [3:0]  tg;
      d  = {$urandom(), $urandom()};
      st = 8'($urandom_range(0, 255));
      tg = 4'($urandom_range(0, 15));
      send(d, st, tg, ref_flags(st));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    acc_clr = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
